// File: rtl/mips_mc_pkg.sv
// Shared definitions for the multi-cycle MIPS control sequencer.
// Contents: FSM state encoding, opcode/funct constants, decode classes,
// ALU-op and datapath mux-select constants, and a memory-state helper.
package mips_mc_pkg;

    typedef enum logic [4:0] {
        S_IDLE   = 5'd0,
        S_FETCH  = 5'd1,
        S_DECODE = 5'd2,
        S_RTYPE  = 5'd3,
        S_RWB    = 5'd4,
        S_JR     = 5'd5,
        S_MEMADR = 5'd6,
        S_MEMRD  = 5'd7,
        S_MEMWB  = 5'd8,
        S_MEMWR  = 5'd9,
        S_BEQ    = 5'd10,
        S_JUMP   = 5'd11,
        S_JAL    = 5'd12,
        S_ADDI   = 5'd13,
        S_LOGI   = 5'd14,
        S_IWB    = 5'd15,
        S_TRAP   = 5'd16
    } state_t;

    typedef enum logic [2:0] {
        CLS_RTYPE   = 3'd0,
        CLS_MEM     = 3'd1,
        CLS_BEQ     = 3'd2,
        CLS_JUMP    = 3'd3,
        CLS_JAL     = 3'd4,
        CLS_ADDI    = 3'd5,
        CLS_LOGI    = 3'd6,
        CLS_ILLEGAL = 3'd7
    } op_class_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] FN_JR    = 6'h08;

    localparam logic [2:0] ALU_ADD   = 3'b000;
    localparam logic [2:0] ALU_SUB   = 3'b001;
    localparam logic [2:0] ALU_FUNCT = 3'b010;
    localparam logic [2:0] ALU_AND   = 3'b011;
    localparam logic [2:0] ALU_OR    = 3'b100;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;
    localparam logic [1:0] PCSRC_RS     = 2'b11;

    localparam logic [1:0] RDST_RT = 2'b00;
    localparam logic [1:0] RDST_RD = 2'b01;
    localparam logic [1:0] RDST_RA = 2'b10;

    localparam logic [1:0] M2R_ALUOUT = 2'b00;
    localparam logic [1:0] M2R_MDR    = 2'b01;
    localparam logic [1:0] M2R_PC     = 2'b10;

    localparam logic       SRCA_PC = 1'b0;
    localparam logic       SRCA_RS = 1'b1;

    localparam logic [1:0] SRCB_RT     = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    // States in which the sequencer waits on the memory handshake.
    function automatic logic is_mem_wait_state(input state_t s);
        return (s == S_FETCH) || (s == S_MEMRD) || (s == S_MEMWR);
    endfunction

endpackage

// File: rtl/mc_ctrl_if.sv
// Control bus between the multi-cycle sequencer and the datapath.
// master: the sequencer (consumes IR fields, ALU zero, memory ready;
//         drives all strobes, mux selects, trap flag and perf counters).
// slave:  the datapath side (the reverse directions).
interface mc_ctrl_if;
    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic        zero;
    logic        mem_ready;

    logic        pc_write;
    logic        pc_write_cond;
    logic [1:0]  pc_source;
    logic        iord;
    logic        mem_read;
    logic        mem_write;
    logic        ir_write;
    logic [1:0]  reg_dst;
    logic [1:0]  mem_to_reg;
    logic        reg_write;
    logic        alu_src_a;
    logic [1:0]  alu_src_b;
    logic        ext_zero;
    logic [2:0]  alu_op;
    logic        illegal_op;
    logic [31:0] cycle_cnt;
    logic [31:0] instr_cnt;

    modport master (
        input  opcode, funct, zero, mem_ready,
        output pc_write, pc_write_cond, pc_source, iord, mem_read, mem_write,
               ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b,
               ext_zero, alu_op, illegal_op, cycle_cnt, instr_cnt
    );

    modport slave (
        output opcode, funct, zero, mem_ready,
        input  pc_write, pc_write_cond, pc_source, iord, mem_read, mem_write,
               ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b,
               ext_zero, alu_op, illegal_op, cycle_cnt, instr_cnt
    );
endinterface

// File: rtl/mc_op_decode.sv
// Combinational instruction classifier for the DECODE/RTYPE/MEMADR/LOGI
// branches of the sequencer.
// Ports:
//   opcode    in  6  IR[31:26]
//   funct     in  6  IR[5:0]
//   op_class  out    next-state class for DECODE
//   is_store  out 1  sw (MEMADR -> MEMWR instead of MEMRD)
//   is_or_imm out 1  ori (LOGI selects OR instead of AND)
//   is_jr     out 1  funct is jr (RTYPE -> JR)
module mc_op_decode
    import mips_mc_pkg::*;
(
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    output op_class_t  op_class,
    output logic       is_store,
    output logic       is_or_imm,
    output logic       is_jr
);

    always_comb begin
        op_class = CLS_ILLEGAL;
        case (opcode)
            OP_RTYPE:       op_class = CLS_RTYPE;
            OP_LW, OP_SW:   op_class = CLS_MEM;
            OP_BEQ:         op_class = CLS_BEQ;
            OP_J:           op_class = CLS_JUMP;
            OP_JAL:         op_class = CLS_JAL;
            OP_ADDI:        op_class = CLS_ADDI;
            OP_ANDI, OP_ORI: op_class = CLS_LOGI;
            default:        op_class = CLS_ILLEGAL;
        endcase
    end

    assign is_store  = (opcode == OP_SW);
    assign is_or_imm = (opcode == OP_ORI);
    assign is_jr     = (funct == FN_JR);

endmodule

// File: rtl/mc_control_fsm.sv
// Multi-cycle MIPS control sequencer (Moore FSM). Steps a shared-ALU,
// shared-memory datapath through fetch/decode/execute/memory/writeback.
// Ports:
//   clk    in   single clock, rising edge
//   reset  in   synchronous, active-high; forces IDLE and gates all strobes
//   bus    master modport of mc_ctrl_if (IR fields, zero, mem_ready in;
//          strobes, mux selects, illegal_op, cycle_cnt, instr_cnt out)
// Parameter TIMEOUT_CYC: consecutive mem_ready=0 cycles tolerated in a
//   memory state before trapping.
// Optional build macro MC_PERF_CNT_EN: builds the cycle/instruction
//   counters; when undefined both counter outputs are tied to zero.
//
// state  | meaning
// IDLE   | first cycle out of reset
// FETCH  | read instruction at PC, PC+4 on completion
// DECODE | branch target into ALUOut, dispatch on opcode
// RTYPE  | rs op rt
// RWB    | R-type result -> rd
// JR     | PC <- rs
// MEMADR | rs + imm address for lw/sw
// MEMRD  | data read at ALUOut
// MEMWB  | MDR -> rt
// MEMWR  | data write at ALUOut
// BEQ    | compare rs/rt, conditional PC load
// JUMP   | PC <- jump address
// JAL    | PC <- jump address, $31 <- PC
// ADDI   | rs + sign-ext imm
// LOGI   | rs and/or zero-ext imm
// IWB    | immediate result -> rt
// TRAP   | illegal opcode or memory timeout; held until reset
module mc_control_fsm
    import mips_mc_pkg::*;
#(
    parameter int TIMEOUT_CYC = 16
) (
    input  logic      clk,
    input  logic      reset,
    mc_ctrl_if.master bus
);

    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);

    state_t    state;
    state_t    next_state;
    op_class_t op_class;
    logic      is_store;
    logic      is_or_imm;
    logic      is_jr;
    logic [TW-1:0] tmo_cnt;
    logic      wait_cycle;
    logic      tmo_hit;

    mc_op_decode u_op_decode (
        .opcode    (bus.opcode),
        .funct     (bus.funct),
        .op_class  (op_class),
        .is_store  (is_store),
        .is_or_imm (is_or_imm),
        .is_jr     (is_jr)
    );

    // A stalled memory cycle; the counter only runs across consecutive stalls.
    assign wait_cycle = is_mem_wait_state(state) && !bus.mem_ready;
    // The stall that brings the run up to TIMEOUT_CYC is the last one allowed.
    assign tmo_hit    = wait_cycle && (tmo_cnt == TMO_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            tmo_cnt <= '0;
        end else if (wait_cycle) begin
            tmo_cnt <= tmo_cnt + 1'b1;
        end else begin
            tmo_cnt <= '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:   next_state = S_FETCH;
            S_FETCH: begin
                if (tmo_hit)            next_state = S_TRAP;
                else if (bus.mem_ready) next_state = S_DECODE;
            end
            S_DECODE: begin
                case (op_class)
                    CLS_RTYPE: next_state = S_RTYPE;
                    CLS_MEM:   next_state = S_MEMADR;
                    CLS_BEQ:   next_state = S_BEQ;
                    CLS_JUMP:  next_state = S_JUMP;
                    CLS_JAL:   next_state = S_JAL;
                    CLS_ADDI:  next_state = S_ADDI;
                    CLS_LOGI:  next_state = S_LOGI;
                    default:   next_state = S_TRAP;
                endcase
            end
            S_RTYPE:  next_state = is_jr ? S_JR : S_RWB;
            S_MEMADR: next_state = is_store ? S_MEMWR : S_MEMRD;
            S_MEMRD: begin
                if (tmo_hit)            next_state = S_TRAP;
                else if (bus.mem_ready) next_state = S_MEMWB;
            end
            S_MEMWR: begin
                if (tmo_hit)            next_state = S_TRAP;
                else if (bus.mem_ready) next_state = S_FETCH;
            end
            S_ADDI, S_LOGI: next_state = S_IWB;
            S_RWB, S_JR, S_MEMWB, S_BEQ, S_JUMP, S_JAL, S_IWB:
                            next_state = S_FETCH;
            S_TRAP:         next_state = S_TRAP;
            default:        next_state = S_TRAP;
        endcase
    end

    // Outputs decode from the state register; reset masks them so an
    // abandoned access never strobes in the reset cycle.
    always_comb begin
        bus.pc_write      = 1'b0;
        bus.pc_write_cond = 1'b0;
        bus.pc_source     = PCSRC_ALU;
        bus.iord          = 1'b0;
        bus.mem_read      = 1'b0;
        bus.mem_write     = 1'b0;
        bus.ir_write      = 1'b0;
        bus.reg_dst       = RDST_RT;
        bus.mem_to_reg    = M2R_ALUOUT;
        bus.reg_write     = 1'b0;
        bus.alu_src_a     = SRCA_PC;
        bus.alu_src_b     = SRCB_RT;
        bus.ext_zero      = 1'b0;
        bus.alu_op        = ALU_ADD;
        bus.illegal_op    = 1'b0;
        if (!reset) begin
            case (state)
                S_FETCH: begin
                    bus.mem_read  = 1'b1;
                    bus.alu_src_b = SRCB_FOUR;
                    // IR load and PC+4 happen in the completing cycle only.
                    bus.ir_write  = bus.mem_ready;
                    bus.pc_write  = bus.mem_ready;
                end
                S_DECODE: bus.alu_src_b = SRCB_IMM_SH;
                S_RTYPE: begin
                    bus.alu_src_a = SRCA_RS;
                    bus.alu_op    = ALU_FUNCT;
                end
                S_RWB: begin
                    bus.reg_dst   = RDST_RD;
                    bus.reg_write = 1'b1;
                end
                S_JR: begin
                    bus.pc_write  = 1'b1;
                    bus.pc_source = PCSRC_RS;
                end
                S_MEMADR, S_ADDI: begin
                    bus.alu_src_a = SRCA_RS;
                    bus.alu_src_b = SRCB_IMM;
                end
                S_MEMRD: begin
                    bus.mem_read = 1'b1;
                    bus.iord     = 1'b1;
                end
                S_MEMWB: begin
                    bus.mem_to_reg = M2R_MDR;
                    bus.reg_write  = 1'b1;
                end
                S_MEMWR: begin
                    bus.mem_write = 1'b1;
                    bus.iord      = 1'b1;
                end
                S_BEQ: begin
                    bus.alu_src_a     = SRCA_RS;
                    bus.alu_op        = ALU_SUB;
                    bus.pc_write_cond = 1'b1;
                    bus.pc_source     = PCSRC_ALUOUT;
                end
                S_JUMP: begin
                    bus.pc_write  = 1'b1;
                    bus.pc_source = PCSRC_JUMP;
                end
                S_JAL: begin
                    // PC was already advanced in FETCH, so PC is the link value.
                    bus.pc_write   = 1'b1;
                    bus.pc_source  = PCSRC_JUMP;
                    bus.reg_write  = 1'b1;
                    bus.reg_dst    = RDST_RA;
                    bus.mem_to_reg = M2R_PC;
                end
                S_LOGI: begin
                    bus.ext_zero  = 1'b1;
                    bus.alu_src_a = SRCA_RS;
                    bus.alu_src_b = SRCB_IMM;
                    bus.alu_op    = is_or_imm ? ALU_OR : ALU_AND;
                end
                S_IWB: bus.reg_write = 1'b1;
                S_TRAP: bus.illegal_op = 1'b1;
                default: ;
            endcase
        end
    end

`ifdef MC_PERF_CNT_EN
    logic [31:0] cycle_q;
    logic [31:0] instr_q;
    logic        instr_done;

    // Entering FETCH from IDLE is not a retirement, and TRAP never leaves.
    assign instr_done = (next_state == S_FETCH) && (state != S_FETCH) &&
                        (state != S_IDLE) && (state != S_TRAP);

    always_ff @(posedge clk) begin
        if (reset) begin
            cycle_q <= '0;
            instr_q <= '0;
        end else begin
            cycle_q <= cycle_q + 32'd1;
            if (instr_done) begin
                instr_q <= instr_q + 32'd1;
            end
        end
    end

    assign bus.cycle_cnt = cycle_q;
    assign bus.instr_cnt = instr_q;
`else
    assign bus.cycle_cnt = 32'd0;
    assign bus.instr_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_mc_control_fsm.sv
module tb_mc_control_fsm;

    typedef struct packed {
        logic        rst;
        logic        rdy;
        logic        z;
        logic [5:0]  op;
        logic [5:0]  fn;
        logic [20:0] w;
    } ent_t;

    logic clk;
    logic reset;
    int   total;
    int   bad;
    ent_t sb[$];
    ent_t e;

    mc_ctrl_if bus ();

    mc_control_fsm #(.TIMEOUT_CYC(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    wire [20:0] obs = {bus.pc_write, bus.pc_write_cond, bus.pc_source, bus.iord,
                       bus.mem_read, bus.mem_write, bus.ir_write, bus.reg_dst,
                       bus.mem_to_reg, bus.reg_write, bus.alu_src_a, bus.alu_src_b,
                       bus.ext_zero, bus.alu_op, bus.illegal_op};

    function automatic logic [20:0] cw(
        input logic pcw, input logic pcc, input logic [1:0] pcs, input logic iord,
        input logic mrd, input logic mwr, input logic irw, input logic [1:0] rdst,
        input logic [1:0] m2r, input logic rw, input logic asa, input logic [1:0] asb,
        input logic ez, input logic [2:0] aop, input logic ill);
        return {pcw, pcc, pcs, iord, mrd, mwr, irw, rdst, m2r, rw, asa, asb, ez, aop, ill};
    endfunction

    logic [20:0] W_ZERO, W_FETCH, W_FSTALL, W_DECODE, W_RTYPE, W_RWB, W_JR;
    logic [20:0] W_MEMADR, W_MEMRD, W_MEMWB, W_MEMWR, W_BEQ, W_JUMP, W_JAL;
    logic [20:0] W_ADDI, W_ANDI, W_ORI, W_IWB, W_TRAP;

    task automatic push(input logic r, input logic rdy, input logic z,
                        input logic [5:0] op, input logic [5:0] fn, input logic [20:0] w);
        ent_t t;
        t = {r, rdy, z, op, fn, w};
        sb.push_back(t);
    endtask

    task automatic push_fd(input logic [5:0] op, input logic [5:0] fn);
        push(0, 1, 0, op, fn, W_FETCH);
        push(0, 1, 0, op, fn, W_DECODE);
    endtask

    task automatic test_reset();
        int i;
        for (int k = 0; k < 3; k++) push(1, 1, 0, 6'h00, 6'h00, W_ZERO);
        i = 0;
        while (sb.size() != 0) begin
            e = sb.pop_front();
            reset = e.rst; bus.mem_ready = e.rdy; bus.zero = e.z;
            bus.opcode = e.op; bus.funct = e.fn;
            @(negedge clk);
            total++;
            if (obs !== e.w) begin
                bad++;
                $display("FAIL reset cyc=%0d got=%h want=%h", i, obs, e.w);
            end
            @(posedge clk); #1;
            i++;
        end
        total++;
        if (bus.cycle_cnt !== 32'd0 || bus.instr_cnt !== 32'd0 || bus.illegal_op !== 1'b0) begin
            bad++;
            $display("FAIL reset_counters got=%0d/%0d/%b want=0/0/0",
                     bus.cycle_cnt, bus.instr_cnt, bus.illegal_op);
        end
        push(0, 1, 0, 6'h00, 6'h00, W_ZERO);
        while (sb.size() != 0) begin
            e = sb.pop_front();
            reset = e.rst; bus.mem_ready = e.rdy; bus.zero = e.z;
            bus.opcode = e.op; bus.funct = e.fn;
            @(negedge clk);
            total++;
            if (obs !== e.w) begin
                bad++;
                $display("FAIL reset_idle got=%h want=%h", obs, e.w);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_lw();
        int i;
        push_fd(6'h23, 6'h00);
        push(0, 1, 0, 6'h23, 6'h00, W_MEMADR);
        push(0, 1, 0, 6'h23, 6'h00, W_MEMRD);
        push(0, 1, 0, 6'h23, 6'h00, W_MEMWB);
        i = 0;
        while (sb.size() != 0) begin
            e = sb.pop_front();
            reset = e.rst; bus.mem_ready = e.rdy; bus.zero = e.z;
            bus.opcode = e.op; bus.funct = e.fn;
            @(negedge clk);
            total++;
            if (obs !== e.w) begin
                bad++;
                $display("FAIL lw cyc=%0d got=%h want=%h", i, obs, e.w);
            end
            @(posedge clk); #1;
            i++;
        end
    endtask

    task automatic test_sw_stall();
        int i;
        push_fd(6'h2B, 6'h00);
        push(0, 1, 0, 6'h2B, 6'h00, W_MEMADR);
        for (int k = 0; k < 3; k++) push(0, 0, 0, 6'h2B, 6'h00, W_MEMWR);
        push(0, 1, 0, 6'h2B, 6'h00, W_MEMWR);
        push(0, 1, 0, 6'h2B, 6'h00, W_FETCH);
        push(0, 1, 0, 6'h02, 6'h00, W_DECODE);
        push(0, 1, 0, 6'h02, 6'h00, W_JUMP);
        i = 0;
        while (sb.size() != 0) begin
            e = sb.pop_front();
            reset = e.rst; bus.mem_ready = e.rdy; bus.zero = e.z;
            bus.opcode = e.op; bus.funct = e.fn;
            @(negedge clk);
            total++;
            if (obs !== e.w) begin
                bad++;
                $display("FAIL sw_stall cyc=%0d got=%h want=%h", i, obs, e.w);
            end
            @(posedge clk); #1;
            i++;
        end
    endtask

    task automatic test_rtype();
        int i;
        push_fd(6'h00, 6'h20);
        push(0, 1, 0, 6'h00, 6'h20, W_RTYPE);
        push(0, 1, 0, 6'h00, 6'h20, W_RWB);
        push_fd(6'h00, 6'h08);
        push(0, 1, 0, 6'h00, 6'h08, W_RTYPE);
        push(0, 1, 0, 6'h00, 6'h08, W_JR);
        i = 0;
        while (sb.size() != 0) begin
            e = sb.pop_front();
            reset = e.rst; bus.mem_ready = e.rdy; bus.zero = e.z;
            bus.opcode = e.op; bus.funct = e.fn;
            @(negedge clk);
            total++;
            if (obs !== e.w) begin
                bad++;
                $display("FAIL rtype cyc=%0d got=%h want=%h", i, obs, e.w);
            end
            @(posedge clk); #1;
            i++;
        end
    endtask

    task automatic test_branch_jump();
        int i;
        push(0, 1, 1, 6'h04, 6'h00, W_FETCH);
        push(0, 1, 1, 6'h04, 6'h00, W_DECODE);
        push(0, 1, 1, 6'h04, 6'h00, W_BEQ);
        push(0, 1, 0, 6'h04, 6'h00, W_FETCH);
        push(0, 1, 0, 6'h04, 6'h00, W_DECODE);
        push(0, 1, 0, 6'h04, 6'h00, W_BEQ);
        push_fd(6'h03, 6'h00);
        push(0, 1, 0, 6'h03, 6'h00, W_JAL);
        push_fd(6'h02, 6'h00);
        push(0, 1, 0, 6'h02, 6'h00, W_JUMP);
        i = 0;
        while (sb.size() != 0) begin
            e = sb.pop_front();
            reset = e.rst; bus.mem_ready = e.rdy; bus.zero = e.z;
            bus.opcode = e.op; bus.funct = e.fn;
            @(negedge clk);
            total++;
            if (obs !== e.w) begin
                bad++;
                $display("FAIL branch_jump cyc=%0d got=%h want=%h", i, obs, e.w);
            end
            @(posedge clk); #1;
            i++;
        end
    endtask

    task automatic test_imm();
        int i;
        push_fd(6'h08, 6'h00);
        push(0, 1, 0, 6'h08, 6'h00, W_ADDI);
        push(0, 1, 0, 6'h08, 6'h00, W_IWB);
        push_fd(6'h0C, 6'h00);
        push(0, 1, 0, 6'h0C, 6'h00, W_ANDI);
        push(0, 1, 0, 6'h0C, 6'h00, W_IWB);
        push_fd(6'h0D, 6'h00);
        push(0, 1, 0, 6'h0D, 6'h00, W_ORI);
        push(0, 1, 0, 6'h0D, 6'h00, W_IWB);
        i = 0;
        while (sb.size() != 0) begin
            e = sb.pop_front();
            reset = e.rst; bus.mem_ready = e.rdy; bus.zero = e.z;
            bus.opcode = e.op; bus.funct = e.fn;
            @(negedge clk);
            total++;
            if (obs !== e.w) begin
                bad++;
                $display("FAIL imm cyc=%0d got=%h want=%h", i, obs, e.w);
            end
            @(posedge clk); #1;
            i++;
        end
    endtask

    task automatic test_mid_reset();
        int i;
        push_fd(6'h23, 6'h00);
        push(0, 1, 0, 6'h23, 6'h00, W_MEMADR);
        push(0, 0, 0, 6'h23, 6'h00, W_MEMRD);
        push(0, 0, 0, 6'h23, 6'h00, W_MEMRD);
        push(1, 0, 0, 6'h23, 6'h00, W_ZERO);
        push(0, 1, 0, 6'h23, 6'h00, W_ZERO);
        i = 0;
        while (sb.size() != 0) begin
            e = sb.pop_front();
            reset = e.rst; bus.mem_ready = e.rdy; bus.zero = e.z;
            bus.opcode = e.op; bus.funct = e.fn;
            @(negedge clk);
            total++;
            if (obs !== e.w) begin
                bad++;
                $display("FAIL mid_reset cyc=%0d got=%h want=%h", i, obs, e.w);
            end
            @(posedge clk); #1;
            i++;
        end
    endtask

    task automatic test_trap();
        int i;
        push_fd(6'h3F, 6'h00);
        push(0, 1, 0, 6'h3F, 6'h00, W_TRAP);
        push(0, 0, 0, 6'h23, 6'h00, W_TRAP);
        push(0, 1, 0, 6'h00, 6'h20, W_TRAP);
        push(1, 1, 0, 6'h00, 6'h20, W_ZERO);
        push(0, 0, 0, 6'h00, 6'h20, W_ZERO);
        for (int k = 0; k < 16; k++) push(0, 0, 0, 6'h00, 6'h20, W_FSTALL);
        push(0, 1, 0, 6'h00, 6'h20, W_TRAP);
        push(0, 1, 0, 6'h00, 6'h20, W_TRAP);
        push(1, 1, 0, 6'h00, 6'h20, W_ZERO);
        push(0, 1, 0, 6'h00, 6'h20, W_ZERO);
        push(0, 1, 0, 6'h00, 6'h20, W_FETCH);
        i = 0;
        while (sb.size() != 0) begin
            e = sb.pop_front();
            reset = e.rst; bus.mem_ready = e.rdy; bus.zero = e.z;
            bus.opcode = e.op; bus.funct = e.fn;
            @(negedge clk);
            total++;
            if (obs !== e.w) begin
                bad++;
                $display("FAIL trap cyc=%0d got=%h want=%h", i, obs, e.w);
            end
            @(posedge clk); #1;
            i++;
        end
    endtask

    task automatic test_perf();
        int i;
        logic [31:0] exp_cyc;
        logic [31:0] exp_ins;
        push(1, 1, 0, 6'h00, 6'h00, W_ZERO);
        push(1, 1, 0, 6'h00, 6'h00, W_ZERO);
        push(0, 1, 0, 6'h00, 6'h00, W_ZERO);
        push_fd(6'h08, 6'h00);
        push(0, 1, 0, 6'h08, 6'h00, W_ADDI);
        push(0, 1, 0, 6'h08, 6'h00, W_IWB);
        push_fd(6'h02, 6'h00);
        push(0, 1, 0, 6'h02, 6'h00, W_JUMP);
        push_fd(6'h2B, 6'h00);
        push(0, 1, 0, 6'h2B, 6'h00, W_MEMADR);
        push(0, 1, 0, 6'h2B, 6'h00, W_MEMWR);
        i = 0;
        while (sb.size() != 0) begin
            e = sb.pop_front();
            reset = e.rst; bus.mem_ready = e.rdy; bus.zero = e.z;
            bus.opcode = e.op; bus.funct = e.fn;
            @(negedge clk);
            total++;
            if (obs !== e.w) begin
                bad++;
                $display("FAIL perf_seq cyc=%0d got=%h want=%h", i, obs, e.w);
            end
            @(posedge clk); #1;
            i++;
        end
`ifdef MC_PERF_CNT_EN
        exp_cyc = 32'd12;
        exp_ins = 32'd3;
`else
        exp_cyc = 32'd0;
        exp_ins = 32'd0;
`endif
        total++;
        if (bus.cycle_cnt !== exp_cyc) begin
            bad++;
            $display("FAIL perf_cycle_cnt got=%0d want=%0d", bus.cycle_cnt, exp_cyc);
        end
        total++;
        if (bus.instr_cnt !== exp_ins) begin
            bad++;
            $display("FAIL perf_instr_cnt got=%0d want=%0d", bus.instr_cnt, exp_ins);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        total = 0;
        bad   = 0;
        reset = 1'b1;
        bus.opcode = 6'h00;
        bus.funct  = 6'h00;
        bus.zero   = 1'b0;
        bus.mem_ready = 1'b1;
        //                pcw pcc pcs    iord mrd mwr irw rdst   m2r    rw asa asb    ez aop     ill
        W_ZERO   = cw(0, 0, 2'b00, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 2'b00, 0, 3'b000, 0);
        W_FETCH  = cw(1, 0, 2'b00, 0, 1, 0, 1, 2'b00, 2'b00, 0, 0, 2'b01, 0, 3'b000, 0);
        W_FSTALL = cw(0, 0, 2'b00, 0, 1, 0, 0, 2'b00, 2'b00, 0, 0, 2'b01, 0, 3'b000, 0);
        W_DECODE = cw(0, 0, 2'b00, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 2'b11, 0, 3'b000, 0);
        W_RTYPE  = cw(0, 0, 2'b00, 0, 0, 0, 0, 2'b00, 2'b00, 0, 1, 2'b00, 0, 3'b010, 0);
        W_RWB    = cw(0, 0, 2'b00, 0, 0, 0, 0, 2'b01, 2'b00, 1, 0, 2'b00, 0, 3'b000, 0);
        W_JR     = cw(1, 0, 2'b11, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 2'b00, 0, 3'b000, 0);
        W_MEMADR = cw(0, 0, 2'b00, 0, 0, 0, 0, 2'b00, 2'b00, 0, 1, 2'b10, 0, 3'b000, 0);
        W_MEMRD  = cw(0, 0, 2'b00, 1, 1, 0, 0, 2'b00, 2'b00, 0, 0, 2'b00, 0, 3'b000, 0);
        W_MEMWB  = cw(0, 0, 2'b00, 0, 0, 0, 0, 2'b00, 2'b01, 1, 0, 2'b00, 0, 3'b000, 0);
        W_MEMWR  = cw(0, 0, 2'b00, 1, 0, 1, 0, 2'b00, 2'b00, 0, 0, 2'b00, 0, 3'b000, 0);
        W_BEQ    = cw(0, 1, 2'b01, 0, 0, 0, 0, 2'b00, 2'b00, 0, 1, 2'b00, 0, 3'b001, 0);
        W_JUMP   = cw(1, 0, 2'b10, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 2'b00, 0, 3'b000, 0);
        W_JAL    = cw(1, 0, 2'b10, 0, 0, 0, 0, 2'b10, 2'b10, 1, 0, 2'b00, 0, 3'b000, 0);
        W_ADDI   = cw(0, 0, 2'b00, 0, 0, 0, 0, 2'b00, 2'b00, 0, 1, 2'b10, 0, 3'b000, 0);
        W_ANDI   = cw(0, 0, 2'b00, 0, 0, 0, 0, 2'b00, 2'b00, 0, 1, 2'b10, 1, 3'b011, 0);
        W_ORI    = cw(0, 0, 2'b00, 0, 0, 0, 0, 2'b00, 2'b00, 0, 1, 2'b10, 1, 3'b100, 0);
        W_IWB    = cw(0, 0, 2'b00, 0, 0, 0, 0, 2'b00, 2'b00, 1, 0, 2'b00, 0, 3'b000, 0);
        W_TRAP   = cw(0, 0, 2'b00, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 2'b00, 0, 3'b000, 1);
        @(posedge clk); #1;

        test_reset();
        test_lw();
        test_sw_stall();
        test_rtype();
        test_branch_jump();
        test_imm();
        test_mid_reset();
        test_trap();
        test_perf();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
